// File: rtl/exe_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
// Define EXE_MDU_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module exe_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_opr1_i,
  input  logic [XLEN-1:0] req_opr2_i,
  input  logic            kill_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opd_q, opd_d;
  logic [2:0]      op_q, op_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_d;

  // Request decode: operand signedness, magnitudes and divide special cases
  logic            is_div;
  logic            s1_signed, s2_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div      = req_op_i[2];
    s1_signed   = (req_op_i == 3'd1) || (req_op_i == 3'd2) ||
                  (req_op_i == 3'd4) || (req_op_i == 3'd6);
    s2_signed   = (req_op_i == 3'd1) || (req_op_i == 3'd4) || (req_op_i == 3'd6);
    a_neg       = s1_signed & req_opr1_i[XLEN-1];
    b_neg       = s2_signed & req_opr2_i[XLEN-1];
    a_mag       = a_neg ? (~req_opr1_i + XLEN'(1)) : req_opr1_i;
    b_mag       = b_neg ? (~req_opr2_i + XLEN'(1)) : req_opr2_i;
    div_zero    = is_div && (req_opr2_i == '0);
    div_ovf     = ((req_op_i == 3'd4) || (req_op_i == 3'd6)) &&
                  (req_opr1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (req_opr2_i == {XLEN{1'b1}});
    special_res = '0;
    if (div_zero) begin
      special_res = req_op_i[1] ? req_opr1_i : {XLEN{1'b1}};
    end else if (div_ovf) begin
      special_res = req_op_i[1] ? '0 : req_opr1_i;
    end
  end

`ifdef EXE_MDU_FAST_MUL_EN
  // Sign-extended operands; the low PW bits of the product are exact for every signedness mix
  logic [PW-1:0]   fast_a, fast_b, fast_prod;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast_a    = {{XLEN{s1_signed & req_opr1_i[XLEN-1]}}, req_opr1_i};
    fast_b    = {{XLEN{s2_signed & req_opr2_i[XLEN-1]}}, req_opr2_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (req_op_i == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
  end
`endif

  // One shift-add multiply step: hi accumulates, lo shifts out the multiplier
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [PW-1:0]   mul_prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi   = mul_sum[XLEN:1];
    mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
    mul_prod = {mul_hi, mul_lo};
    if (neg_res_q) begin
      mul_prod = ~mul_prod + PW'(1);
    end
    mul_res  = (op_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[PW-1:XLEN];
  end

  // One restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in
  logic [XLEN:0]   div_trial;
  logic            q_bit;
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res;

  always_comb begin
    div_trial = {hi_q, lo_q[XLEN-1]};
    q_bit     = (div_trial >= {1'b0, opd_q});
    div_hi    = q_bit ? XLEN'(div_trial - {1'b0, opd_q}) : div_trial[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], q_bit};
    quo_fix   = neg_res_q ? (~div_lo + XLEN'(1)) : div_lo;
    rem_fix   = neg_rem_q ? (~div_hi + XLEN'(1)) : div_hi;
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  // Next-state and datapath update; kill overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = rsp_result_o;

    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            op_d      = req_op_i;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = CNT_W'(XLEN - 1);
            if (is_div) begin
              hi_d  = '0;
              lo_d  = a_mag;
              opd_d = b_mag;
              if (div_zero || div_ovf) begin
                state_d  = S_DONE;
                result_d = special_res;
              end else begin
                state_d = S_DIV;
              end
            end else begin
`ifdef EXE_MDU_FAST_MUL_EN
              state_d  = S_DONE;
              result_d = fast_res;
`else
              hi_d    = '0;
              lo_d    = b_mag;
              opd_d   = a_mag;
              state_d = S_MUL;
`endif
            end
          end
        end
        S_MUL: begin
          hi_d  = mul_hi;
          lo_d  = mul_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = mul_res;
          end
        end
        S_DIV: begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = div_res;
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered status outputs follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opd_q        <= '0;
      op_q         <= '0;
      neg_res_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      rsp_result_o <= '0;
      rsp_valid_o  <= 1'b0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opd_q        <= opd_d;
      op_q         <= op_d;
      neg_res_q    <= neg_res_d;
      neg_rem_q    <= neg_rem_d;
      rsp_result_o <= result_d;
      rsp_valid_o  <= (state_d == S_DONE);
      req_ready_o  <= (state_d == S_IDLE);
      busy_o       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// Scoreboard bench for exe_mdu: directed M-extension cases plus randomized ops against an arithmetic model.
module tb_exe_mdu;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_opr1_i;
  logic [XLEN-1:0] req_opr2_i;
  logic            kill_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_result_o;
  logic            busy_o;

  exe_mdu #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_opr1_i   (req_opr1_i),
    .req_opr2_i   (req_opr2_i),
    .kill_i       (kill_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bp_mode = 0;  // 0 random, 1 hold low, 2 always high

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the RISC-V M rules
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        pu = ua / ub;
        return pu[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        pu = ua % ub;
        return pu[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 32'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
`ifdef EXE_MDU_FAST_MUL_EN
    return 1;
`else
    return XLEN + 1;
`endif
  endfunction

  // Backpressure driver, updated 1 time unit after each rising edge
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1)      rsp_ready_i = 1'b0;
      else if (bp_mode == 2) rsp_ready_i = 1'b1;
      else                   rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first valid, stability under backpressure, result on transfer
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_result = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (rsp_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_rsp", 64'(rsp_result_o), 64'd0);
        end else begin
          chk((cyc - exp_q[0].t) == exp_q[0].lat, "latency",
              64'(cyc - exp_q[0].t), 64'(exp_q[0].lat));
        end
      end
      if (rsp_valid_o && prev_valid && !prev_ready) begin
        chk(rsp_result_o == prev_result, "result_stable", 64'(rsp_result_o), 64'(prev_result));
      end
      if (rsp_valid_o && rsp_ready_i && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(rsp_result_o == e.res, "result", 64'(rsp_result_o), 64'(e.res));
      end
      prev_valid  = rsp_valid_o;
      prev_ready  = rsp_ready_i;
      prev_result = rsp_result_o;
    end
  end

  // Issue one request at the next cycle; returns the accept cycle T
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp_res, output int t);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    while (!req_ready_o && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(req_ready_o == 1'b1, "ready_wait", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_opr1_i  = a;
    req_opr2_i  = b;
    t = cyc;
    if (push) exp_q.push_back('{res: exp_res, lat: lat_of(op, a, b), t: cyc});
    @(posedge clk);
    #2;
    req_valid_i = 1'b0;
    req_op_i    = 3'($urandom_range(0, 7));
    req_opr1_i  = $urandom;
    req_opr2_i  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1};
  logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_r  [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                             32'd1, 32'd0};

  initial begin
    int          t;
    int          n;
    logic [2:0]  op;
    logic [31:0] a, b, held;

    rst = 1'b1;
    req_valid_i = 1'b0;
    req_op_i = '0;
    req_opr1_i = '0;
    req_opr2_i = '0;
    kill_i = 1'b0;
    repeat (3) @(negedge clk);
    chk(rsp_valid_o == 1'b0, "rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk(rsp_result_o == '0, "rst_rsp_result", 64'(rsp_result_o), 64'd0);
    chk(busy_o == 1'b0, "rst_busy", 64'(busy_o), 64'd0);
    chk(req_ready_o == 1'b1, "rst_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed cases with hand-derived expected values
    for (int i = 0; i < 14; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1, d_r[i], t);
      drain();
    end

    // Randomized operations against the model
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b, 1'b1, model(op, a, b), t);
    end
    drain();

    // Kill an in-flight divide at T+10
    issue(3'd4, 32'd1000, 32'd3, 1'b0, 32'd0, t);
    while (cyc < t + 10) begin
      @(posedge clk);
      #2;
    end
    kill_i = 1'b1;
    @(posedge clk);
    #2;
    kill_i = 1'b0;
    @(negedge clk);
    chk(cyc == t + 11, "kill_cycle", 64'(cyc - t), 64'd11);
    chk(req_ready_o == 1'b1, "kill_ready", 64'(req_ready_o), 64'd1);
    chk(busy_o == 1'b0, "kill_busy", 64'(busy_o), 64'd0);
    chk(rsp_valid_o == 1'b0, "kill_rsp_valid", 64'(rsp_valid_o), 64'd0);
    repeat (50) @(negedge clk);

    // Kill together with a request in IDLE: not accepted
    @(posedge clk);
    #2;
    req_valid_i = 1'b1;
    req_op_i    = 3'd0;
    req_opr1_i  = 32'd3;
    req_opr2_i  = 32'd4;
    kill_i      = 1'b1;
    @(posedge clk);
    #2;
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    @(negedge clk);
    chk(busy_o == 1'b0, "kill_accept_busy", 64'(busy_o), 64'd0);
    chk(req_ready_o == 1'b1, "kill_accept_ready", 64'(req_ready_o), 64'd1);
    repeat (40) @(negedge clk);

    // Hold the response for 5 cycles, then release
    bp_mode = 1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, t);
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(rsp_valid_o == 1'b1, "hold_rsp_arrives", 64'(rsp_valid_o), 64'd1);
    held = rsp_result_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(rsp_valid_o == 1'b1, "hold_valid", 64'(rsp_valid_o), 64'd1);
      chk(rsp_result_o == held, "hold_result", 64'(rsp_result_o), 64'(held));
      chk(req_ready_o == 1'b0, "hold_ready", 64'(req_ready_o), 64'd0);
    end
    bp_mode = 2;
    n = 0;
    while (rsp_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(rsp_valid_o == 1'b0, "release_valid", 64'(rsp_valid_o), 64'd0);
    chk(req_ready_o == 1'b1, "release_ready", 64'(req_ready_o), 64'd1);
    chk(exp_q.size() == 0, "release_popped", 64'(exp_q.size()), 64'd0);
    bp_mode = 0;

    // Reset in the middle of an operation discards it
    issue(3'd5, 32'd12345, 32'd17, 1'b0, 32'd0, t);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk(rsp_valid_o == 1'b0, "midrst_valid", 64'(rsp_valid_o), 64'd0);
    chk(busy_o == 1'b0, "midrst_busy", 64'(busy_o), 64'd0);
    chk(req_ready_o == 1'b1, "midrst_ready", 64'(req_ready_o), 64'd1);
    chk(rsp_result_o == '0, "midrst_result", 64'(rsp_result_o), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (50) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
